// File: rtl/regfile_mp_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_if
// Bundle of every non-clock signal on the multi-port register file.
//
// Two sides use it:
//   master : the decode/writeback side. It drives the read addresses, the
//            write ports, the retire flags and the issue strobe.
//   slave  : the register file. It returns read data, per-port busy bits and
//            the full scoreboard vector.
//
// Signals (packed buses, port k / j occupies slice [k*W +: W]):
//   rd_addr  NRD*AW    read addresses
//   rd_data  NRD*XLEN  read data
//   rd_busy  NRD       scoreboard bit of each read address
//   wr_en    NWR       write enables
//   wr_addr  NWR*AW    write addresses
//   wr_data  NWR*XLEN  write data
//   wr_clr   NWR       write also retires a producer (clears busy)
//   iss_en   1         issue strobe
//   iss_addr AW        destination register being issued
//   busy_vec NREG      full scoreboard, bit 0 always 0
// ----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [NREG-1:0]     busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port integer register file with a per-register busy
// scoreboard for the decode stage.
//
//   - NREG registers of XLEN bits; register 0 always reads zero and can never
//     be written or marked busy.
//   - NWR write ports committing at the rising clock edge; when several ports
//     hit the same register in one cycle the highest-numbered port wins.
//   - NRD combinational read ports. With BYPASS=1 a read of a register being
//     written this cycle returns the incoming data (highest port wins);
//     with BYPASS=0 it returns the stored value.
//   - Scoreboard: issue sets a register's busy bit, a write flagged wr_clr
//     clears it, and issue wins when both hit the same register.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears registers and scoreboard,
//          and forces all read data to zero while held low
//   rf     regfile_mp_if.slave bundle (read, write, issue, scoreboard)
// ----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave rf
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]     r_regs [NREG];
    logic [NREG-1:0]     r_busy;

    logic [NREG-1:0]     w_we;
    logic [NREG-1:0]     w_set;
    logic [NREG-1:0]     w_clr;
    logic [XLEN-1:0]     w_wd [NREG];

    logic [AW-1:0]       w_ra;
    logic [XLEN-1:0]     w_rv;
    logic [NRD*XLEN-1:0] w_rd_data;
    logic [NRD-1:0]      w_rd_busy;

    // Per-register write/issue/retire decode. Ports are scanned in ascending
    // order so the last matching (highest) port overrides the data. Register 0
    // never decodes a hit, which keeps it at zero and never busy.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_we[r]  = 1'b0;
            w_clr[r] = 1'b0;
            w_wd[r]  = '0;
            w_set[r] = rf.iss_en && (rf.iss_addr == AW'(r)) && (r != 0);
            for (int j = 0; j < NWR; j++) begin
                if (rf.wr_en[j] && (rf.wr_addr[j*AW +: AW] == AW'(r)) && (r != 0)) begin
                    w_we[r] = 1'b1;
                    w_wd[r] = rf.wr_data[j*XLEN +: XLEN];
                    if (rf.wr_clr[j]) begin
                        w_clr[r] = 1'b1;
                    end
                end
            end
        end
    end

    // Storage and scoreboard. Issue has priority over retire: a newly issued
    // producer supersedes the one retiring in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_we[r]) begin
                    r_regs[r] <= w_wd[r];
                end
            end
            r_busy <= w_set | (r_busy & ~w_clr);
        end
    end

    // Read ports. The busy bit is taken from registered state only; the
    // hazard unit pairs it with its own forwarding of same-cycle retires.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        w_ra      = '0;
        w_rv      = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra = rf.rd_addr[k*AW +: AW];
            w_rv = r_regs[w_ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (rf.wr_en[j] && (rf.wr_addr[j*AW +: AW] == w_ra) && (w_ra != '0)) begin
                        w_rv = rf.wr_data[j*XLEN +: XLEN];
                    end
                end
            end
            // Bypassed data would otherwise leak through while reset is held.
            w_rd_data[k*XLEN +: XLEN] = rst_n ? w_rv : '0;
            w_rd_busy[k]              = r_busy[w_ra];
        end
    end

    assign rf.rd_data  = w_rd_data;
    assign rf.rd_busy  = w_rd_busy;
    assign rf.busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp. Three instances share one stimulus:
//   dut_a : XLEN=32, NREG=32, NRD=2, NWR=2, BYPASS=1
//   dut_b : same geometry, BYPASS=0
//   dut_c : XLEN=64, NREG=16, NRD=3, NWR=1, BYPASS=1
// The driver applies inputs on the falling edge and queues the values a
// behavioural model predicts; a monitor pops and compares them shortly after.
// ----------------------------------------------------------------------------
module tb_regfile_mp;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) ifa (), ifb ();
    regfile_mp_if #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1)) ifc ();

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rf(ifa));
    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rf(ifb));
    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .rf(ifc));

    typedef struct {
        int          d;
        int          kind;   // 0 rd_data, 1 rd_busy, 2 busy_vec
        int          port;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int c_nreg [3] = '{32, 32, 16};
    int c_nrd  [3] = '{2, 2, 3};
    int c_nwr  [3] = '{2, 2, 1};
    int c_byp  [3] = '{1, 0, 1};
    int c_xw   [3] = '{32, 32, 64};

    // Architectural state of each instance.
    logic [63:0] m_reg  [3][32];
    bit          m_busy [3][32];

    // Current stimulus.
    bit          s_rst;
    bit          s_wen  [2];
    int          s_wa   [2];
    logic [63:0] s_wd   [2];
    bit          s_wclr [2];
    bit          s_iss;
    int          s_ia;
    int          s_ra   [3];
    string       phase;

    function automatic logic [63:0] dmask(int d, logic [63:0] v);
        return (c_xw[d] == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
    endfunction

    function automatic int amask(int d, int a);
        return a & (c_nreg[d] - 1);
    endfunction

    function automatic logic [63:0] exp_rd(int d, int k);
        int a;
        logic [63:0] v;
        a = amask(d, s_ra[k]);
        if (!rst_n || a == 0) return 64'd0;
        v = m_reg[d][a];
        if (c_byp[d] != 0)
            for (int j = 0; j < c_nwr[d]; j++)
                if (s_wen[j] && amask(d, s_wa[j]) == a) v = dmask(d, s_wd[j]);
        return v;
    endfunction

    function automatic logic [63:0] exp_bv(int d);
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < c_nreg[d]; r++) v[r] = m_busy[d][r];
        return v;
    endfunction

    function automatic logic [63:0] actual(int d, int kind, int port);
        logic [63:0] v;
        v = '0;
        case (d)
            0: case (kind)
                   0: v[31:0] = ifa.rd_data[port*32 +: 32];
                   1: v[0]    = ifa.rd_busy[port];
                   default: v[31:0] = ifa.busy_vec;
               endcase
            1: case (kind)
                   0: v[31:0] = ifb.rd_data[port*32 +: 32];
                   1: v[0]    = ifb.rd_busy[port];
                   default: v[31:0] = ifb.busy_vec;
               endcase
            default: case (kind)
                   0: v = ifc.rd_data[port*64 +: 64];
                   1: v[0] = ifc.rd_busy[port];
                   default: v[15:0] = ifc.busy_vec;
               endcase
        endcase
        return v;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 32; r++) begin
                m_reg[d][r]  = '0;
                m_busy[d][r] = 1'b0;
            end
    endtask

    task automatic model_clock(int d);
        bit st, cl;
        for (int j = 0; j < c_nwr[d]; j++)
            if (s_wen[j] && amask(d, s_wa[j]) != 0)
                m_reg[d][amask(d, s_wa[j])] = dmask(d, s_wd[j]);
        for (int r = 1; r < c_nreg[d]; r++) begin
            st = s_iss && (amask(d, s_ia) == r);
            cl = 1'b0;
            for (int j = 0; j < c_nwr[d]; j++)
                if (s_wen[j] && s_wclr[j] && amask(d, s_wa[j]) == r) cl = 1'b1;
            if (st)      m_busy[d][r] = 1'b1;
            else if (cl) m_busy[d][r] = 1'b0;
        end
    endtask

    task automatic idle();
        s_wen  = '{0, 0};
        s_wa   = '{0, 0};
        s_wd   = '{64'd0, 64'd0};
        s_wclr = '{0, 0};
        s_iss  = 1'b0;
        s_ia   = 0;
        s_ra   = '{0, 0, 0};
    endtask

    task automatic drive();
        for (int j = 0; j < 2; j++) begin
            ifa.wr_en[j] = s_wen[j];  ifb.wr_en[j] = s_wen[j];
            ifa.wr_clr[j] = s_wclr[j]; ifb.wr_clr[j] = s_wclr[j];
            ifa.wr_addr[j*5 +: 5] = 5'(s_wa[j]); ifb.wr_addr[j*5 +: 5] = 5'(s_wa[j]);
            ifa.wr_data[j*32 +: 32] = s_wd[j][31:0]; ifb.wr_data[j*32 +: 32] = s_wd[j][31:0];
        end
        ifa.iss_en = s_iss; ifb.iss_en = s_iss;
        ifa.iss_addr = 5'(s_ia); ifb.iss_addr = 5'(s_ia);
        ifa.rd_addr = {5'(s_ra[1]), 5'(s_ra[0])};
        ifb.rd_addr = {5'(s_ra[1]), 5'(s_ra[0])};
        ifc.wr_en = s_wen[0];
        ifc.wr_clr = s_wclr[0];
        ifc.wr_addr = 4'(s_wa[0]);
        ifc.wr_data = s_wd[0];
        ifc.iss_en = s_iss;
        ifc.iss_addr = 4'(s_ia);
        ifc.rd_addr = {4'(s_ra[2]), 4'(s_ra[1]), 4'(s_ra[0])};
    endtask

    task automatic push(int d, int kind, int port, logic [63:0] v);
        exp_t e;
        string kn;
        kn = (kind == 0) ? "rd_data" : ((kind == 1) ? "rd_busy" : "busy_vec");
        e.d = d; e.kind = kind; e.port = port; e.exp = v;
        e.name = $sformatf("%s/dut%0d/%s%0d", phase, d, kn, port);
        q.push_back(e);
    endtask

    // One cycle: drive at the falling edge, queue predictions, advance the
    // model at the rising edge.
    task automatic step();
        @(negedge clk);
        rst_n = s_rst;
        if (!s_rst) clear_model();
        drive();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < c_nrd[d]; k++) begin
                push(d, 0, k, exp_rd(d, k));
                push(d, 1, k, {63'd0, m_busy[d][amask(d, s_ra[k])]});
            end
            push(d, 2, 0, exp_bv(d));
        end
        @(posedge clk);
        if (s_rst)
            for (int d = 0; d < 3; d++) model_clock(d);
    endtask

    // Monitor: compare everything queued for this cycle after the outputs settle.
    initial begin
        exp_t e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                act = actual(e.d, e.kind, e.port);
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        phase = "init";
        s_rst = 1'b0;
        idle();
        clear_model();
        drive();

        phase = "reset";
        step(); step();
        s_rst = 1'b1; step();

        phase = "async_reset";
        s_wen[0] = 1; s_wa[0] = 5; s_wd[0] = 64'hDEAD_BEEF; s_ra = '{5, 5, 5};
        step();
        idle(); s_ra = '{5, 5, 5}; step();
        s_rst = 1'b0; step();
        s_rst = 1'b1; step(); step();

        phase = "x0_x7";
        idle(); s_wen[0] = 1; s_wa[0] = 0; s_wd[0] = 64'h1234; step();
        idle(); s_wen[0] = 1; s_wa[0] = 7; s_wd[0] = 64'hA5A5_A5A5; step();
        idle(); s_ra = '{0, 7, 7}; step();

        phase = "bypass";
        idle(); s_wen[0] = 1; s_wa[0] = 3; s_wd[0] = 64'h11; s_ra = '{3, 3, 3}; step();
        idle(); s_ra = '{3, 3, 3}; step();

        phase = "collide";
        idle(); s_wen = '{1, 1}; s_wa = '{9, 9}; s_wd = '{64'h1, 64'h2}; s_ra = '{9, 9, 9}; step();
        idle(); s_ra = '{9, 9, 9}; step();

        phase = "scoreboard";
        idle(); s_iss = 1; s_ia = 4; s_ra = '{4, 4, 4}; step();
        idle(); s_ra = '{4, 4, 4}; step();
        idle(); s_wen[0] = 1; s_wclr[0] = 1; s_wa[0] = 4; s_wd[0] = 64'h44; s_ra = '{4, 4, 4}; step();
        idle(); s_ra = '{4, 4, 4}; step();
        idle(); s_iss = 1; s_ia = 4; s_wen[1] = 1; s_wclr[1] = 1; s_wa[1] = 4; s_wd[1] = 64'h45;
        s_wen[0] = 1; s_wclr[0] = 1; s_wa[0] = 4; s_wd[0] = 64'h46; step();
        idle(); s_ra = '{4, 4, 4}; step();
        idle(); s_iss = 1; s_ia = 0; step();
        idle(); step();

        phase = "wide";
        idle(); s_wen[0] = 1; s_wa[0] = 15; s_wd[0] = 64'hFFFF_0000_FFFF_0000;
        s_iss = 1; s_ia = 15; s_ra = '{15, 15, 15}; step();
        idle(); s_ra = '{15, 15, 15}; step();
        idle(); s_wen[0] = 1; s_wclr[0] = 1; s_wa[0] = 15; s_wd[0] = 64'h0123_4567_89AB_CDEF;
        s_ra = '{15, 15, 15}; step();
        idle(); s_ra = '{15, 15, 15}; step();

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            s_rst = ($urandom_range(0, 63) != 0);
            for (int j = 0; j < 2; j++) begin
                s_wen[j]  = $urandom_range(0, 1);
                s_wclr[j] = $urandom_range(0, 1);
                s_wa[j]   = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
                s_wd[j]   = {$urandom, $urandom};
            end
            s_iss = $urandom_range(0, 1);
            s_ia  = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            for (int k = 0; k < 3; k++)
                s_ra[k] = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            step();
        end

        s_rst = 1'b1;
        idle();
        step();
        @(negedge clk);
        #4;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
